// File: rtl/hq_pkg.sv
// Shared types, widths, limits and helper functions for the HaveQuick TOD
// transmitter: FSM state enum, captured time-of-day record, field range
// check and the extended Hamming(8,4) digit code.
package hq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PREAMBLE,
        ST_SYNC,
        ST_DATA
    } state_e;

    // Field widths of the binary time-of-day inputs
    localparam int HH_W  = 8;
    localparam int MM_W  = 8;
    localparam int SS_W  = 8;
    localparam int DOY_W = 12;
    localparam int YY_W  = 8;

    // Frame geometry
    localparam int DIGITS    = 11;
    localparam int DATA_BITS = DIGITS * 8;
    localparam int SYNC_BITS = 16;

    // Range limits (hh/mm/yy exclusive upper bounds, ss/doy inclusive)
    localparam logic [HH_W-1:0]  HH_LIMIT = 8'd24;
    localparam logic [MM_W-1:0]  MM_LIMIT = 8'd60;
    localparam logic [SS_W-1:0]  SS_MAX   = 8'd60;
    localparam logic [DOY_W-1:0] DOY_MIN  = 12'd1;
    localparam logic [DOY_W-1:0] DOY_MAX  = 12'd366;
    localparam logic [YY_W-1:0]  YY_LIMIT = 8'd100;

    typedef struct packed {
        logic [YY_W-1:0]  yy;
        logic [DOY_W-1:0] doy;
        logic [HH_W-1:0]  hh;
        logic [MM_W-1:0]  mm;
        logic [SS_W-1:0]  ss;
    } tod_t;

    // Extended Hamming(8,4): data nibble first, then p0..p2 and overall parity p3
    function automatic logic [7:0] hamming84(input logic [3:0] d);
        logic p0, p1, p2, p3;
        p0 = d[3] ^ d[2] ^ d[1];
        p1 = d[3] ^ d[2] ^ d[0];
        p2 = d[3] ^ d[1] ^ d[0];
        p3 = ^d ^ p0 ^ p1 ^ p2;
        return {d, p0, p1, p2, p3};
    endfunction

    // True when every field of the sample is a legal UTC value
    function automatic logic tod_in_range(input tod_t t);
        return (t.hh < HH_LIMIT) && (t.mm < MM_LIMIT) && (t.ss <= SS_MAX) &&
               (t.doy >= DOY_MIN) && (t.doy <= DOY_MAX) && (t.yy < YY_LIMIT);
    endfunction

endpackage

// File: rtl/hq_bcd_encode.sv
// Combinational binary-to-BCD conversion of a captured time-of-day sample,
// with each digit protected by the extended Hamming(8,4) code. Digit 0
// (yy tens) lands in the most significant byte so the frame can be shifted
// out MSB first.
module hq_bcd_encode
    import hq_pkg::*;
(
    input  tod_t                 tod_i,
    output logic [DATA_BITS-1:0] code_o
);

    logic [3:0] dig [DIGITS];

    // Units digit of a value, reached through a 12-bit remainder
    function automatic logic [3:0] low_digit(input logic [11:0] v);
        logic [11:0] r;
        r = v % 12'd10;
        return r[3:0];
    endfunction

    // Split the fields into decimal digits in transmission order, then encode
    always_comb begin
        logic [11:0] yy12, hh12, mm12, ss12, doy12;
        yy12  = {4'd0, tod_i.yy};
        hh12  = {4'd0, tod_i.hh};
        mm12  = {4'd0, tod_i.mm};
        ss12  = {4'd0, tod_i.ss};
        doy12 = tod_i.doy;

        dig[0]  = low_digit(yy12 / 12'd10);
        dig[1]  = low_digit(yy12);
        dig[2]  = low_digit(doy12 / 12'd100);
        dig[3]  = low_digit(doy12 / 12'd10);
        dig[4]  = low_digit(doy12);
        dig[5]  = low_digit(hh12 / 12'd10);
        dig[6]  = low_digit(hh12);
        dig[7]  = low_digit(mm12 / 12'd10);
        dig[8]  = low_digit(mm12);
        dig[9]  = low_digit(ss12 / 12'd10);
        dig[10] = low_digit(ss12);

        code_o = '0;
        for (int i = 0; i < DIGITS; i++) begin
            code_o[DATA_BITS-1-8*i -: 8] = hamming84(dig[i]);
        end
    end

endmodule

// File: rtl/havequick_tod_tx.sv
// HaveQuick time-of-day frame transmitter.
// Captures one UTC sample on tod_valid, waits for PPS, then sends an
// alternating preamble, the sync word and 88 Hamming-protected BCD data bits,
// each bit held CLKS_PER_BIT clocks (CLKS_PER_BIT must be >= 2 and even).
// Build option: define HQ_MANCHESTER_EN to send every bit as Manchester
// (bit value in the first half-period, its complement in the second);
// otherwise the line is plain NRZ.
module havequick_tod_tx
    import hq_pkg::*;
#(
    parameter int          CLKS_PER_BIT  = 20000,
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [15:0] SYNC_WORD     = 16'hEB90
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tod_valid,
    input  logic [HH_W-1:0]  hh,
    input  logic [MM_W-1:0]  mm,
    input  logic [SS_W-1:0]  ss,
    input  logic [DOY_W-1:0] doy,
    input  logic [YY_W-1:0]  yy,
    input  logic             pps,
    output logic             tx_line,
    output logic             busy,
    output logic             armed,
    output logic             done,
    output logic             range_err,
    output logic             overrun
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]        PRE_LAST = 8'(PREAMBLE_BITS - 1);
    localparam logic [7:0]        SYN_LAST = 8'(SYNC_BITS - 1);
    localparam logic [7:0]        DAT_LAST = 8'(DATA_BITS - 1);

    state_e                state_q,     state_d;
    tod_t                  shadow_q,    shadow_d;
    logic [DATA_BITS-1:0]  data_sr_q,   data_sr_d;
    logic [CNT_W-1:0]      clk_cnt_q,   clk_cnt_d;
    logic [7:0]            bit_cnt_q,   bit_cnt_d;
    logic                  done_q,      done_d;
    logic                  range_err_q, range_err_d;
    logic                  overrun_q,   overrun_d;

    tod_t                  in_tod;
    logic                  in_ok;
    logic                  bit_end;
    logic [DATA_BITS-1:0]  enc_vec;
    logic [3:0]            sync_idx;
    logic                  nrz_bit;

    assign in_tod  = '{yy: yy, doy: doy, hh: hh, mm: mm, ss: ss};
    assign in_ok   = tod_in_range(in_tod);
    assign bit_end = (clk_cnt_q == LAST_CLK);

    // Encoding is taken from the shadow so it is ready on the PPS cycle
    hq_bcd_encode u_enc (
        .tod_i  (shadow_q),
        .code_o (enc_vec)
    );

    // Next-state, capture and pulse logic
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_d     = state_q;
        shadow_d    = shadow_q;
        data_sr_d   = data_sr_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        done_d      = 1'b0;
        range_err_d = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // pps here is ignored, even together with tod_valid
                if (tod_valid) begin
                    if (in_ok) begin
                        shadow_d = in_tod;
                        state_d  = ST_ARMED;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end
            end

            ST_ARMED: begin
                if (pps) begin
                    // The frame uses the sample already held; a coincident one is dropped
                    data_sr_d = enc_vec;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_PREAMBLE;
                    overrun_d = tod_valid;
                end else if (tod_valid) begin
                    if (in_ok) begin
                        shadow_d = in_tod;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end
            end

            ST_PREAMBLE, ST_SYNC, ST_DATA: begin
                overrun_d = tod_valid;
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (state_q == ST_PREAMBLE) begin
                        if (bit_cnt_q == PRE_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = ST_SYNC;
                        end
                    end else if (state_q == ST_SYNC) begin
                        if (bit_cnt_q == SYN_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = ST_DATA;
                        end
                    end else begin
                        data_sr_d = data_sr_q << 1;
                        if (bit_cnt_q == DAT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = ST_IDLE;
                            done_d    = 1'b1;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, shadow, shift register and counter storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            // NOTE: shadow and shift register are reset too, so no frame can ever carry pre-reset data.
            shadow_q    <= '0;
            data_sr_q   <= '0;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            data_sr_q   <= data_sr_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sync_idx = 4'd15 - bit_cnt_q[3:0];

    // Current frame bit selected from the active section
    always_comb begin
        nrz_bit = 1'b0;
        case (state_q)
            ST_PREAMBLE: nrz_bit = ~bit_cnt_q[0];
            ST_SYNC:     nrz_bit = SYNC_WORD[sync_idx];
            ST_DATA:     nrz_bit = data_sr_q[DATA_BITS-1];
            default:     nrz_bit = 1'b0;
        endcase
    end

    assign busy      = (state_q == ST_PREAMBLE) || (state_q == ST_SYNC) || (state_q == ST_DATA);
    assign armed     = (state_q == ST_ARMED);
    assign done      = done_q;
    assign range_err = range_err_q;
    assign overrun   = overrun_q;

`ifdef HQ_MANCHESTER_EN
    localparam logic [CNT_W-1:0] HALF_CLK = CNT_W'(CLKS_PER_BIT / 2);
    logic second_half;
    assign second_half = (clk_cnt_q >= HALF_CLK);
    assign tx_line     = busy & (nrz_bit ^ second_half);
`else
    assign tx_line = busy & nrz_bit;
`endif

endmodule

// File: tb/tb_havequick_tod_tx.sv
// Self-checking bench for havequick_tod_tx with CLKS_PER_BIT=8,
// PREAMBLE_BITS=16. A frame-level model predicts every output on every
// cycle; directed scenarios pin specific bytes and timings with literals,
// then a randomized phase exercises the strobe interactions.
module tb_havequick_tod_tx;

    localparam int CPB       = 8;
    localparam int PRE_BITS  = 16;
    localparam int FRAME_BIT = PRE_BITS + 16 + 88;
    localparam int FRAME_CYC = FRAME_BIT * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tod_valid = 1'b0;
    logic [7:0] hh = '0, mm = '0, ss = '0, yy = '0;
    logic [11:0] doy = '0;
    logic       pps = 1'b0;
    logic       tx_line, busy, armed, done, range_err, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    havequick_tod_tx #(
        .CLKS_PER_BIT  (CPB),
        .PREAMBLE_BITS (PRE_BITS),
        .SYNC_WORD     (16'hEB90)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tod_valid (tod_valid),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .doy       (doy),
        .yy        (yy),
        .pps       (pps),
        .tx_line   (tx_line),
        .busy      (busy),
        .armed     (armed),
        .done      (done),
        .range_err (range_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_active, m_armed, m_done, m_rerr, m_ovr;
    int m_fcyc;
    int m_yy, m_doy, m_hh, m_mm, m_ss;
    bit frame [FRAME_BIT];

    function automatic bit in_range(int y, int d, int h, int m, int s);
        return (h < 24) && (m < 60) && (s <= 60) && (d >= 1) && (d <= 366) && (y < 100);
    endfunction

    function automatic int hq_code(int dig);
        int d3, d2, d1, d0, p0, p1, p2, p3;
        d3 = (dig >> 3) & 1; d2 = (dig >> 2) & 1; d1 = (dig >> 1) & 1; d0 = dig & 1;
        p0 = d3 ^ d2 ^ d1;
        p1 = d3 ^ d2 ^ d0;
        p2 = d3 ^ d1 ^ d0;
        p3 = d3 ^ d2 ^ d1 ^ d0 ^ p0 ^ p1 ^ p2;
        return dig * 16 + p0 * 8 + p1 * 4 + p2 * 2 + p3;
    endfunction

    task automatic build_frame(input int y, input int d, input int h, input int m, input int s);
        int digs [11];
        int sync_w;
        int code;
        sync_w = 16'hEB90;
        digs = '{y / 10, y % 10, d / 100, (d / 10) % 10, d % 10,
                 h / 10, h % 10, m / 10, m % 10, s / 10, s % 10};
        for (int i = 0; i < PRE_BITS; i++) frame[i] = (i % 2 == 0);
        for (int j = 0; j < 16; j++) frame[PRE_BITS + j] = ((sync_w >> (15 - j)) & 1) != 0;
        for (int k = 0; k < 11; k++) begin
            code = hq_code(digs[k]);
            for (int b = 0; b < 8; b++)
                frame[PRE_BITS + 16 + 8 * k + b] = ((code >> (7 - b)) & 1) != 0;
        end
    endtask

    // Model advances on each rising edge from the inputs the DUT sees
    always @(posedge clk) begin
        bit ok;
        if (rst) begin
            m_active = 0; m_armed = 0; m_fcyc = 0;
            m_done = 0; m_rerr = 0; m_ovr = 0;
            m_yy = 0; m_doy = 0; m_hh = 0; m_mm = 0; m_ss = 0;
        end else begin
            m_done = 0; m_rerr = 0; m_ovr = 0;
            ok = in_range(int'(yy), int'(doy), int'(hh), int'(mm), int'(ss));
            if (m_active) begin
                if (tod_valid) m_ovr = 1;
                m_fcyc++;
                if (m_fcyc == FRAME_CYC) begin
                    m_active = 0; m_fcyc = 0; m_done = 1;
                end
            end else if (m_armed) begin
                if (pps) begin
                    build_frame(m_yy, m_doy, m_hh, m_mm, m_ss);
                    m_active = 1; m_fcyc = 0; m_armed = 0;
                    if (tod_valid) m_ovr = 1;
                end else if (tod_valid) begin
                    if (ok) begin
                        m_yy = int'(yy); m_doy = int'(doy); m_hh = int'(hh); m_mm = int'(mm); m_ss = int'(ss);
                    end else m_rerr = 1;
                end
            end else if (tod_valid) begin
                if (ok) begin
                    m_yy = int'(yy); m_doy = int'(doy); m_hh = int'(hh); m_mm = int'(mm); m_ss = int'(ss);
                    m_armed = 1;
                end else m_rerr = 1;
            end
        end
    end

    // ---------------- compare process ----------------
    int  cyc_n = 0;
    int  busy_start = 0;
    int  frame_len = 0;
    bit  prev_busy = 0;
    bit  rec_bits [FRAME_BIT];
    logic [7:0] first8 = '0;

    always @(negedge clk) begin
        bit b, exp_tx;
        int ph;
        cyc_n++;
        exp_tx = 0;
        if (m_active) begin
            b  = frame[m_fcyc / CPB];
            ph = m_fcyc % CPB;
`ifdef HQ_MANCHESTER_EN
            exp_tx = (ph >= CPB / 2) ? !b : b;
`else
            exp_tx = b;
`endif
            if (ph == 2) rec_bits[m_fcyc / CPB] = tx_line;
            if (m_fcyc < 8) first8[7 - m_fcyc] = tx_line;
        end
        check("tx_line",   tx_line,   exp_tx);
        check("busy",      busy,      m_active);
        check("armed",     armed,     m_armed);
        check("done",      done,      m_done);
        check("range_err", range_err, m_rerr);
        check("overrun",   overrun,   m_ovr);
        if (busy && !prev_busy) busy_start = cyc_n;
        if (done) frame_len = cyc_n - busy_start;
        prev_busy = busy;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input bit tv, input bit p, input int y, input int d,
                         input int h, input int m, input int s);
        tod_valid = tv; pps = p;
        yy = 8'(y); doy = 12'(d); hh = 8'(h); mm = 8'(m); ss = 8'(s);
        tick();
        tod_valid = 1'b0; pps = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (!busy && !armed) break;
            tick();
        end
        check(name, (i < limit), 1);
    endtask

    function automatic logic [7:0] rec_byte(int k);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[7 - b] = rec_bits[PRE_BITS + 16 + 8 * k + b];
        return v;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        repeat (3) tick();
        check("reset_tx",   tx_line, 0);
        check("reset_busy", busy,    0);
        check("reset_armed", armed,  0);
        rst = 1'b0;
        tick();

        // Model pins: known code bytes
        check("model_code2", hq_code(2), 8'h2B);
        check("model_code1", hq_code(1), 8'h17);

        // Basic frame
        pulse(1, 0, 25, 123, 13, 45, 7);
        check("basic_armed", armed, 1);
        repeat (9) tick();
        pulse(0, 1, 0, 0, 0, 0, 0);
        check("basic_busy", busy, 1);
        wait_idle("basic_end", 2 * FRAME_CYC);
        check("basic_yy_tens",  rec_byte(0),  8'h2B);
        check("basic_doy_hund", rec_byte(2),  8'h17);
        check("basic_ss_units", rec_byte(10), 8'h71);
        check("basic_len",      frame_len,    FRAME_CYC);
`ifdef HQ_MANCHESTER_EN
        check("first_bit_wave", first8, 8'b1111_0000);
`else
        check("first_bit_wave", first8, 8'b1111_1111);
`endif

        // Range check: hh=24 rejected, pps then does nothing
        pulse(1, 0, 25, 123, 24, 0, 0);
        check("range_err_pulse", range_err, 1);
        check("range_armed", armed, 0);
        pulse(0, 1, 0, 0, 0, 0, 0);
        repeat (4) tick();
        check("range_no_frame", busy, 0);

        // Latest wins, then overrun mid-frame
        pulse(1, 0, 25, 123, 13, 45, 7);
        repeat (3) tick();
        pulse(1, 0, 25, 123, 13, 45, 8);
        repeat (3) tick();
        pulse(0, 1, 0, 0, 0, 0, 0);
        repeat (98) tick();
        pulse(1, 0, 1, 1, 1, 1, 1);
        check("overrun_pulse", overrun, 1);
        wait_idle("latest_end", 2 * FRAME_CYC);
        check("latest_ss_units", rec_byte(10), 8'h8E);

        // Simultaneous strobes in IDLE
        pulse(1, 1, 30, 200, 5, 6, 9);
        check("simul_armed", armed, 1);
        check("simul_busy",  busy,  0);
        repeat (5) tick();
        check("simul_still_idle", busy, 0);
        pulse(0, 1, 0, 0, 0, 0, 0);
        check("simul_start", busy, 1);
        wait_idle("simul_end", 2 * FRAME_CYC);

        // Boundary values accepted / rejected
        pulse(1, 0, 99, 366, 23, 59, 60);
        check("bound_hi_armed", armed, 1);
        pulse(0, 1, 0, 0, 0, 0, 0);
        wait_idle("bound_end", 2 * FRAME_CYC);
        pulse(1, 0, 10, 0, 1, 1, 1);
        check("doy0_reject", range_err, 1);
        pulse(1, 0, 10, 10, 1, 1, 61);
        check("ss61_reject", range_err, 1);

        // Reset mid-DATA
        pulse(1, 0, 25, 123, 13, 45, 7);
        pulse(0, 1, 0, 0, 0, 0, 0);
        repeat (499) tick();
        rst = 1'b1;
        #1;
        check("rst_tx",    tx_line, 0);
        check("rst_busy",  busy,    0);
        check("rst_armed", armed,   0);
        tick();
        rst = 1'b0;
        tick();
        pulse(0, 1, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("rst_no_frame", busy, 0);

        // Randomized interaction of strobes, fields and occasional reset
        for (int c = 0; c < 30000; c++) begin
            tod_valid = ($urandom_range(0, 99) < 3);
            pps       = ($urandom_range(0, 299) == 0);
            hh  = 8'($urandom_range(0, 25));
            mm  = 8'($urandom_range(0, 61));
            ss  = 8'($urandom_range(0, 62));
            doy = 12'($urandom_range(0, 368));
            yy  = 8'($urandom_range(0, 101));
            rst = ($urandom_range(0, 9999) == 0);
            tick();
        end
        tod_valid = 1'b0; pps = 1'b0; rst = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/havequick_tod_tx.md
Name: havequick_tod_tx

Overview:
- Downstream of the GPS-to-UTC converter stage.
- Captures one UTC time-of-day sample (hh, mm, ss, doy, yy) and converts it to BCD digits.
- Protects each digit with an extended Hamming(8,4) code and serialises a HaveQuick TOD frame on the next PPS.
- Output drives the HaveQuick line driver; the frame is a preamble, a sync word, then 88 data bits.

Parameters:
- CLKS_PER_BIT, 20000, clk cycles per transmitted bit; must be ≥2 and even.
- PREAMBLE_BITS, 16, number of alternating preamble bits, starting with 1.
- SYNC_WORD, 16'hEB90, frame sync word, sent MSB first.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- tod_valid  in  1  1-clk strobe; fields below are valid on this cycle.
- hh  in  8  hours, binary.
- mm  in  8  minutes, binary.
- ss  in  8  seconds, binary.
- doy  in  12  day of year, binary.
- yy  in  8  two-digit year, binary.
- pps  in  1  1-clk synchronous PPS strobe; the frame starts on it.
- tx_line  out  1  serial HaveQuick output.
- busy  out  1  high from frame start to last bit end.
- armed  out  1  sample captured, waiting for PPS.
- done  out  1  1-clk pulse, cycle after the final bit period.
- range_err  out  1  1-clk pulse: tod_valid with out-of-range fields.
- overrun  out  1  1-clk pulse: tod_valid while busy.

Behaviour:
- Reset values: all outputs 0; FSM returns to IDLE; shadow registers and counters cleared.
- Reset mid-frame aborts immediately; tx_line returns to 0.
- FSM states: IDLE, ARMED, PREAMBLE, SYNC, DATA. Transitions:
  - IDLE → ARMED on a valid tod_valid.
  - ARMED → PREAMBLE on pps.
  - PREAMBLE → SYNC after PREAMBLE_BITS bits.
  - SYNC → DATA after 16 bits.
  - DATA → IDLE after 88 bits; done pulses on the IDLE-entry cycle.
- Range check: hh<24, mm<60, ss≤60, 1≤doy≤366, yy<100.
  - Failure: range_err pulses, no capture, state unchanged.
- tod_valid in ARMED: the new sample replaces the shadow (latest wins).
- tod_valid in PREAMBLE, SYNC or DATA: ignored; overrun pulses. If it is also out of range, overrun only.
- tod_valid and pps on the same cycle in IDLE: capture only, no start. The frame waits for the next pps.
- tod_valid and pps on the same cycle in ARMED: the transmission uses the old shadow; the new sample is dropped and overrun pulses.
- pps in IDLE is ignored.
- Digit order (11 digits): yy tens, yy units, doy hundreds, doy tens, doy units, hh tens, hh units, mm tens, mm units, ss tens, ss units.
- Binary-to-BCD conversion uses constant divide/modulo on the captured fields.
- Code byte per digit d3..d0: {d3,d2,d1,d0,p0,p1,p2,p3}, MSB first.
  - p0=d3^d2^d1; p1=d3^d2^d0; p2=d3^d1^d0; p3=XOR of the other 7 bits.
- Encoded bytes are computed in the ARMED→PREAMBLE transition and loaded into an 88-bit shift register.
- Timing: first bit appears on tx_line the cycle after pps is sampled. Each bit is held exactly CLKS_PER_BIT cycles; the bit counter wraps 0..CLKS_PER_BIT-1.
- Frame length: (PREAMBLE_BITS+16+88)·CLKS_PER_BIT cycles.
- busy is high for the entire frame; tx_line is 0 when not busy.
- armed is high in ARMED only.

Optional Feature:
- Macro HQ_MANCHESTER_EN.
- Defined: each bit period splits into halves. First CLKS_PER_BIT/2 cycles = bit, second half = ~bit (1 → high-then-low). Framing and timing are otherwise unchanged.
- Undefined: plain NRZ as above.

Decomposition:
- Package hq_pkg:
  - FSM state enum.
  - Field widths.
  - Digit count (11) and data bit count (88).
  - Range limits.
  - Function hamming84(nibble) → byte.
- Sub-module hq_bcd_encode: combinational; captured binary fields in → 88-bit encoded vector out.
- FSM, counters and shift register live in the top module.

Test Plan:
All scenarios use CLKS_PER_BIT=8 and PREAMBLE_BITS=16.
- Basic frame: tod_valid with yy=25, doy=123, hh=13, mm=45, ss=07, then pps 10 cycles later.
  - tx_line shows 1010…(16 bits), EB90, then digits 2,5,1,2,3,1,3,4,5,0,7.
  - Digit 2 encodes as 8'h2B; digit 1 as 8'h17.
  - done fires 960 cycles after the first bit.
- Range check: tod_valid with hh=24 → range_err pulse, armed stays 0, pps produces no frame.
- Latest-wins and overrun: tod_valid ss=07, then ss=08 before pps → frame carries 08. A further tod_valid at the 100th frame cycle → overrun pulse, frame unchanged.
- Simultaneous strobes: tod_valid and pps together in IDLE → armed=1, no frame; the next pps starts the frame.
- Reset mid-DATA: assert rst at the 500th frame cycle → tx_line, busy, armed all 0 immediately. A subsequent pps alone produces no frame.
- HQ_MANCHESTER_EN defined: the first preamble bit gives tx_line high 4 cycles then low 4 cycles. Total frame length is still 960 cycles.
